// File: rtl/seq_det_pkg.sv
// Shared definitions for the 10010 non-overlapping Mealy detector: state
// encoding, pattern length and the single-step transition function.
package seq_det_pkg;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  localparam int PAT_LEN = 5;

  typedef struct packed {
    logic [2:0] nxt;
    logic       hit;
  } step_t;

  // Unused encodings fall back to S0 so a corrupted saved state self-heals.
  function automatic step_t seq_step(input logic [2:0] st, input logic b);
    step_t r;
    r.nxt = S0;
    r.hit = 1'b0;
    case (st)
      S0: r.nxt = b ? S1 : S0;
      S1: r.nxt = b ? S1 : S2;
      S2: r.nxt = b ? S1 : S3;
      S3: r.nxt = b ? S4 : S0;
      S4: begin
        r.nxt = b ? S1 : S0;
        r.hit = ~b;
      end
      default: r.nxt = S0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq10010_channel_scheduler_if.sv
// Channel-side handshake plus detection/statistics outputs of the scheduler.
interface seq10010_channel_scheduler_if #(
  parameter int NCH     = 4,
  parameter int COUNT_W = 8
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]     in_valid;
  logic [NCH-1:0]     in_bit;
  logic [NCH-1:0]     in_ready;
  logic               det_valid;
  logic [CW-1:0]      det_ch;
  logic [CW-1:0]      cnt_sel;
  logic [COUNT_W-1:0] cnt_val;

  modport master (
    output in_valid, in_bit, cnt_sel,
    input  in_ready, det_valid, det_ch, cnt_val
  );

  modport slave (
    input  in_valid, in_bit, cnt_sel,
    output in_ready, det_valid, det_ch, cnt_val
  );

endinterface

// File: rtl/seq10010_step.sv
// Purely combinational 10010 detector step: (state, bit) -> (next state, hit).
module seq10010_step
  import seq_det_pkg::*;
(
  input  logic [2:0] st_i,
  input  logic       bit_i,
  output logic [2:0] nxt_o,
  output logic       hit_o
);

  step_t r;

  assign r     = seq_step(st_i, bit_i);
  assign nxt_o = r.nxt;
  assign hit_o = r.hit;

endmodule

// File: rtl/seq10010_channel_scheduler.sv
// Round-robin time-multiplexing of one 10010 detector step across NCH serial
// channels, each with a one-bit input buffer, saved state and hit counter.
module seq10010_channel_scheduler
  import seq_det_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int COUNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  seq10010_channel_scheduler_if.slave bus
);

  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]     buf_v_q, buf_v_d;
  logic [NCH-1:0]     buf_b_q, buf_b_d;
  logic [2:0]         st_q  [NCH];
  logic [2:0]         st_d  [NCH];
  logic [COUNT_W-1:0] cnt_q [NCH];
  logic [COUNT_W-1:0] cnt_d [NCH];
  logic [CW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               det_valid_q, det_valid_d;
  logic [CW-1:0]      det_ch_q, det_ch_d;

  logic               gnt_found;
  logic [CW-1:0]      gnt_idx;
  logic [NCH-1:0]     grant;
  logic [NCH-1:0]     accept;
  logic [2:0]         step_nxt;
  logic               step_hit;

  // First buffered channel at or after rr_ptr, searching upward with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (enable && !clear) begin
      for (int k = 0; k < NCH; k++) begin
        if (!gnt_found && buf_v_q[CW'((int'(rr_ptr_q) + k) % NCH)]) begin
          gnt_found = 1'b1;
          gnt_idx   = CW'((int'(rr_ptr_q) + k) % NCH);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_found) grant[gnt_idx] = 1'b1;
  end

  seq10010_step u_step (
    .st_i  (st_q[gnt_idx]),
    .bit_i (buf_b_q[gnt_idx]),
    .nxt_o (step_nxt),
    .hit_o (step_hit)
  );

  // Ready depends only on registered state, grant and clear; a served buffer
  // can be refilled on the same edge it drains.
  assign bus.in_ready = {NCH{~clear}} & (~buf_v_q | grant);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    buf_v_d     = (buf_v_q & ~grant) | accept;
    buf_b_d     = (accept & bus.in_bit) | (~accept & buf_b_q);
    st_d        = st_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    det_valid_d = 1'b0;
    det_ch_d    = det_ch_q;

    if (gnt_found) begin
      st_d[gnt_idx] = step_nxt;
      rr_ptr_d      = CW'((int'(gnt_idx) + 1) % NCH);
      if (step_hit) begin
        det_valid_d = 1'b1;
        det_ch_d    = gnt_idx;
        if (cnt_q[gnt_idx] != '1) cnt_d[gnt_idx] = cnt_q[gnt_idx] + COUNT_W'(1);
      end
    end

    if (clear) begin
      buf_v_d     = '0;
      rr_ptr_d    = '0;
      det_valid_d = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        st_d[i]  = S0;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_v_q     <= '0;
      buf_b_q     <= '0;
      rr_ptr_q    <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= S0;
        cnt_q[i] <= '0;
      end
    end else begin
      buf_v_q     <= buf_v_d;
      buf_b_q     <= buf_b_d;
      rr_ptr_q    <= rr_ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.det_valid = det_valid_q;
  assign bus.det_ch    = det_ch_q;
  assign bus.cnt_val   = cnt_q[bus.cnt_sel];

endmodule
